// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Synchronous, loadable down-counter/timer with one-shot and auto-reload
//   modes. Counts down from a programmed value and flags terminal count.
//   All state updates on the falling edge of clk; reset is asynchronous
//   and active-low.
//
// Ports
//   clk          clock, state updates on the falling edge
//   reset        asynchronous active-low reset
//   load         load q and the reload register from load_value
//   load_value   value captured by load
//   start        IDLE/EXPIRED -> RUN
//   stop         RUN -> IDLE, q held
//   enable       count qualifier while in RUN
//   auto_reload  1: periodic mode, 0: one-shot mode
//   q            current count
//   busy         state is RUN
//   done         state is EXPIRED
//   tc           registered one-cycle terminal-count pulse
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] reload_reg, reload_nx;
    logic [WIDTH-1:0] q_nx;
    logic             tc_nx;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nx;
            q          <= q_nx;
            reload_reg <= reload_nx;
            tc         <= tc_nx;
        end
    end

    // Priority chain load > stop > start > count. An asserted stop outside
    // RUN does nothing but still masks a simultaneous start.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        reload_nx = reload_reg;
        tc_nx     = 1'b0;
        if (load) begin
            q_nx      = load_value;
            reload_nx = load_value;
            state_nx  = (state == RUN) ? RUN : IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                state_nx = IDLE;
            end
        end else if (start && (state != RUN)) begin
            state_nx = RUN;
        end else if ((state == RUN) && enable) begin
            if (q > ONE) begin
                q_nx = q - ONE;
            end else begin
                // q is 1 or 0: terminal edge. A loaded zero always expires,
                // so the counter can never wrap to all-ones.
                tc_nx = 1'b1;
                if ((q == ONE) && auto_reload && (reload_reg != '0)) begin
                    q_nx = reload_reg;
                end else begin
                    q_nx     = '0;
                    state_nx = EXPIRED;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == EXPIRED);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load, start, stop, enable, auto_reload;
    logic [W-1:0] load_value;
    logic [W-1:0] q;
    logic         busy, done, tc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    typedef struct {
        bit       ld;
        bit [3:0] lv;
        bit       st;
        bit       sp;
        bit       en;
        bit       ar;
        int       eq;
        bit       eb;
        bit       ed;
        bit       et;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int eq, input bit eb,
                             input bit ed, input bit et);
        check({name, ".q"}, int'(q), eq);
        check({name, ".busy"}, int'(busy), int'(eb));
        check({name, ".done"}, int'(done), int'(ed));
        check({name, ".tc"}, int'(tc), int'(et));
    endtask

    task automatic drive(input bit ld, input int lv, input bit st, input bit sp,
                         input bit en, input bit ar);
        load        = ld;
        load_value  = W'(lv);
        start       = st;
        stop        = sp;
        enable      = en;
        auto_reload = ar;
    endtask

    // Inputs change 1 time unit after the active (falling) edge; outputs are
    // sampled at that same point, well clear of the next falling edge.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    function automatic vec_t v(bit ld, int lv, bit st, bit sp, bit en, bit ar,
                               int eq, bit eb, bit ed, bit et);
        vec_t r;
        r.ld = ld; r.lv = 4'(lv); r.st = st; r.sp = sp; r.en = en; r.ar = ar;
        r.eq = eq; r.eb = eb; r.ed = ed; r.et = et;
        return r;
    endfunction

    // Reference model: counters and flags, updated by the priority rules.
    int m_q, m_rl;
    bit m_run, m_exp, m_tc;

    task automatic model_step(input bit ld, input int lv, input bit st,
                              input bit sp, input bit en, input bit ar);
        m_tc = 0;
        if (ld) begin
            m_q   = lv;
            m_rl  = lv;
            m_exp = 0;
        end else if (sp) begin
            m_run = 0;
        end else if (st && !m_run) begin
            m_run = 1;
            m_exp = 0;
        end else if (m_run && en) begin
            if (m_q > 1) begin
                m_q = m_q - 1;
            end else begin
                m_tc = 1;
                if (m_q == 1 && ar && m_rl != 0) begin
                    m_q = m_rl;
                end else begin
                    m_q   = 0;
                    m_run = 0;
                    m_exp = 1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        check_all("reset", 0, 0, 0, 0);
        tick;
        reset = 1'b1;
        tick;
        check_all("post_reset", 0, 0, 0, 0);

        // One-shot
        vecs.push_back(v(1, 3, 0, 0, 0, 0, 3, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 0, 3, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        // Auto-reload, 12 enabled edges
        vecs.push_back(v(1, 4, 0, 0, 0, 1, 4, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 4, 1, 0, 0));
        for (int p = 0; p < 3; p++) begin
            vecs.push_back(v(0, 0, 0, 0, 1, 1, 3, 1, 0, 0));
            vecs.push_back(v(0, 0, 0, 0, 1, 1, 2, 1, 0, 0));
            vecs.push_back(v(0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
            vecs.push_back(v(0, 0, 0, 0, 1, 1, 4, 1, 0, 1));
        end
        // Zero load in auto-reload mode
        vecs.push_back(v(0, 0, 0, 1, 1, 1, 4, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ld, int'(vecs[i].lv), vecs[i].st, vecs[i].sp,
                  vecs[i].en, vecs[i].ar);
            tick;
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb,
                      vecs[i].ed, vecs[i].et);
        end

        // Reset mid-count: must clear before any clock edge
        do_reset;
        drive(1, 9, 0, 0, 0, 0); tick;
        drive(0, 0, 1, 0, 0, 0); tick;
        drive(0, 0, 0, 0, 1, 0); tick; tick; tick;
        check_all("pre_reset", 6, 1, 0, 0);
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        tick;
        check_all("reset_held", 0, 0, 0, 0);
        reset = 1'b1;

        // Enable gating and stop/resume
        drive(1, 15, 0, 0, 0, 0); tick;
        drive(0, 0, 1, 0, 0, 0);  tick; check_all("en_start", 15, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);  tick; check_all("en1a", 14, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);  tick; check_all("en0a", 14, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);  tick; check_all("en1b", 13, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);  tick; check_all("en0b", 13, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0);  tick; check_all("stop", 13, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);  tick; check_all("restart", 13, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);  tick; check_all("resume", 12, 1, 0, 0);

        // Priority: load beats start, load in RUN keeps RUN
        do_reset;
        drive(1, 7, 1, 0, 0, 0);  tick; check_all("load_start", 7, 0, 0, 0);
        drive(1, 10, 0, 0, 0, 0); tick;
        drive(0, 0, 1, 0, 0, 0);  tick;
        drive(0, 0, 0, 0, 1, 0);  tick; check_all("run_q9", 9, 1, 0, 0);
        drive(1, 2, 0, 0, 1, 0);  tick; check_all("load_in_run", 2, 1, 0, 0);

        // Randomized against the model
        do_reset;
        m_q = 0; m_rl = 0; m_run = 0; m_exp = 0; m_tc = 0;
        for (int c = 0; c < 600; c++) begin
            bit ld, st, sp, en, ar;
            int lv;
            if ($urandom_range(63) == 0) begin
                reset = 1'b0;
                #1;
                m_q = 0; m_rl = 0; m_run = 0; m_exp = 0; m_tc = 0;
                check_all("rnd_reset", m_q, m_run, m_exp, m_tc);
                reset = 1'b1;
            end
            ld = ($urandom_range(9) == 0);
            lv = ($urandom_range(3) == 0) ? int'($urandom_range(2)) : int'($urandom_range(15));
            st = ($urandom_range(3) == 0);
            sp = ($urandom_range(15) == 0);
            en = ($urandom_range(3) != 0);
            ar = ($urandom_range(2) != 0);
            drive(ld, lv, st, sp, en, ar);
            model_step(ld, lv, st, sp, en, ar);
            tick;
            check_all($sformatf("rnd%0d", c), m_q, m_run, m_exp, m_tc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
